// File: rtl/trigger_frame_receiver.sv
// Trigger link receive framer.
// Delineates 10-byte SOP/EOP frames from the decoded byte stream, checks the
// CRC8 (poly 0x07, MSB-first, init 0) over bytes 1..7, publishes the fields of
// the last good frame, pulses on trigger frames and tracks link lock/statistics.
module trigger_frame_receiver #(
  parameter logic [7:0] SOP          = 8'h3C,
  parameter logic [7:0] EOP          = 8'hBC,
  parameter logic [7:0] TRIGGER_MASK = 8'h10,
  parameter int         LOCK_FRAMES  = 4,
  parameter int         CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           rx_data,
  input  logic                 rx_is_k,
  input  logic                 rx_valid,
  input  logic                 rx_code_err,
  output logic                 trigger_pulse,
  output logic                 frame_ok,
  output logic                 crc_error,
  output logic                 frame_error,
  output logic [7:0]           last_status,
  output logic [15:0]          last_addr,
  output logic [31:0]          last_data,
  output logic                 link_up,
  output logic [CNT_WIDTH-1:0] frame_count,
  output logic [CNT_WIDTH-1:0] error_count
);

  localparam int LOCK_W = $clog2(LOCK_FRAMES + 1);

  typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK, TAIL} state_t;

  state_t      state_reg, state_next;
  logic [2:0]  idx_reg, idx_next;
  logic [7:0]  crc_reg, crc_next;
  logic [55:0] shadow_reg, shadow_next;   // {status, control, addr0, d3, d2, d1, d0}
  logic        match_reg, match_next;
  logic        good_evt, crc_evt, frm_evt;
  logic        is_sop, is_eop;
  logic [LOCK_W-1:0] good_cnt_reg;

  // One byte of CRC8, polynomial x^8+x^2+x+1, MSB first.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

  assign is_sop = rx_is_k && (rx_data == SOP);
  assign is_eop = rx_is_k && (rx_data == EOP);

  // Framing FSM next-state logic; stalls (rx_valid=0) leave everything untouched.
  always_comb begin
    state_next  = state_reg;
    idx_next    = idx_reg;
    crc_next    = crc_reg;
    shadow_next = shadow_reg;
    match_next  = match_reg;
    good_evt    = 1'b0;
    crc_evt     = 1'b0;
    frm_evt     = 1'b0;
    if (rx_valid && (state_reg != HUNT) && rx_code_err) begin
      // A decoder violation inside a frame poisons the whole frame.
      frm_evt    = 1'b1;
      state_next = HUNT;
    end else if (rx_valid && (state_reg != HUNT) && is_sop) begin
      // Unexpected SOP aborts the current frame but also starts a new one.
      frm_evt    = 1'b1;
      state_next = PAYLOAD;
      crc_next   = 8'h00;
      idx_next   = 3'd0;
    end else if (rx_valid) begin
      case (state_reg)
        HUNT: begin
          if (is_sop && !rx_code_err) begin
            state_next = PAYLOAD;
            crc_next   = 8'h00;
            idx_next   = 3'd0;
          end
        end
        PAYLOAD: begin
          if (rx_is_k) begin
            frm_evt    = 1'b1;
            state_next = HUNT;
          end else begin
            crc_next    = crc8_byte(crc_reg, rx_data);
            shadow_next = {shadow_reg[47:0], rx_data};
            if (idx_reg == 3'd6) state_next = CHECK;
            else                 idx_next   = idx_reg + 3'd1;
          end
        end
        CHECK: begin
          if (rx_is_k) begin
            frm_evt    = 1'b1;
            state_next = HUNT;
          end else begin
            match_next = (rx_data == crc_reg);
            state_next = TAIL;
          end
        end
        TAIL: begin
          if (is_eop) begin
            good_evt = match_reg;
            crc_evt  = !match_reg;
          end else begin
            frm_evt = 1'b1;
          end
          state_next = HUNT;
        end
        default: state_next = HUNT;
      endcase
    end
  end

  // Framing FSM state, CRC accumulator and frame shadow register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= HUNT;
      idx_reg    <= 3'd0;
      crc_reg    <= 8'h00;
      shadow_reg <= '0;
      match_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      idx_reg    <= idx_next;
      crc_reg    <= crc_next;
      shadow_reg <= shadow_next;
      match_reg  <= match_next;
    end
  end

  // Registered event pulses, last-good-frame fields and saturating statistics.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trigger_pulse <= 1'b0;
      frame_ok      <= 1'b0;
      crc_error     <= 1'b0;
      frame_error   <= 1'b0;
      last_status   <= 8'h00;
      last_addr     <= 16'h0000;
      last_data     <= 32'h0;
      frame_count   <= '0;
      error_count   <= '0;
    end else begin
      trigger_pulse <= good_evt && ((shadow_reg[47:40] & TRIGGER_MASK) != 8'h00);
      frame_ok      <= good_evt;
      crc_error     <= crc_evt;
      frame_error   <= frm_evt;
      if (good_evt) begin
        last_status <= shadow_reg[55:48];
        last_addr   <= shadow_reg[47:32];
        last_data   <= shadow_reg[31:0];
        if (frame_count != '1) frame_count <= frame_count + CNT_WIDTH'(1);
      end
      if ((crc_evt || frm_evt) && (error_count != '1))
        error_count <= error_count + CNT_WIDTH'(1);
    end
  end

  // Consecutive-good-frame counter; any error drops lock on the same edge as its pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      good_cnt_reg <= '0;
    end else if (crc_evt || frm_evt) begin
      good_cnt_reg <= '0;
    end else if (good_evt && (good_cnt_reg != LOCK_W'(LOCK_FRAMES))) begin
      good_cnt_reg <= good_cnt_reg + LOCK_W'(1);
    end
  end

  assign link_up = (good_cnt_reg == LOCK_W'(LOCK_FRAMES));

endmodule

// File: tb/tb_trigger_frame_receiver.sv
// Directed self-checking bench for trigger_frame_receiver.
module tb_trigger_frame_receiver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_is_k = 1'b0;
  logic        rx_valid = 1'b0;
  logic        rx_code_err = 1'b0;
  logic        trigger_pulse, frame_ok, crc_error, frame_error, link_up;
  logic [7:0]  last_status;
  logic [15:0] last_addr;
  logic [31:0] last_data;
  logic [15:0] frame_count, error_count;

  int checks = 0;
  int errors = 0;

  trigger_frame_receiver dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_is_k(rx_is_k), .rx_valid(rx_valid), .rx_code_err(rx_code_err),
    .trigger_pulse(trigger_pulse), .frame_ok(frame_ok), .crc_error(crc_error),
    .frame_error(frame_error), .last_status(last_status), .last_addr(last_addr),
    .last_data(last_data), .link_up(link_up), .frame_count(frame_count),
    .error_count(error_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-20s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Independent reference CRC8 (0x07, MSB-first) for the non-trivial frame.
  function automatic logic [7:0] ref_crc(input logic [7:0] b [7]);
    logic [7:0] c = 8'h00;
    for (int i = 0; i < 7; i++) begin
      c = c ^ b[i];
      for (int j = 0; j < 8; j++) c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

  // One accepted byte; outputs are observed 1 time unit after the sampling edge.
  task automatic send_byte(input logic [7:0] d, input logic k, input logic err = 1'b0);
    rx_data = d; rx_is_k = k; rx_code_err = err; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_code_err = 1'b0;
  endtask

  // Stall cycle carrying junk that must be ignored.
  task automatic stall();
    rx_data = 8'hBC; rx_is_k = 1'b1; rx_code_err = 1'b1; rx_valid = 1'b0;
    @(posedge clk); #1;
    rx_code_err = 1'b0;
  endtask

  task automatic idle_cycle();
    rx_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  // Full frame; checks that nothing pulses before EOP is accepted.
  task automatic send_frame(input logic [7:0] st, input logic [7:0] ctl, input logic [7:0] ad,
                            input logic [31:0] dt, input logic [7:0] crc, input logic gaps);
    logic [7:0] b [10];
    b = '{8'h3C, st, ctl, ad, dt[31:24], dt[23:16], dt[15:8], dt[7:0], crc, 8'hBC};
    for (int i = 0; i < 10; i++) begin
      send_byte(b[i], (i == 0) || (i == 9));
      if (i == 8) check("pre_eop_quiet", {28'h0, trigger_pulse, frame_ok, crc_error, frame_error}, 32'h0);
      if (gaps && i != 9) stall();
    end
  endtask

  logic [7:0] pay [7];
  logic [7:0] crc_x;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_pulses", {28'h0, trigger_pulse, frame_ok, crc_error, frame_error}, 32'h0);
    check("rst_link_up", 32'(link_up), 32'h0);
    check("rst_frame_count", 32'(frame_count), 32'h0);
    check("rst_error_count", 32'(error_count), 32'h0);
    check("rst_last_addr", 32'(last_addr), 32'h0);
    check("rst_last_data", last_data, 32'h0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    // Idle frame
    send_frame(8'h00, 8'h00, 8'h00, 32'h0, 8'h00, 1'b0);
    check("idle_frame_ok", 32'(frame_ok), 32'h1);
    check("idle_trigger", 32'(trigger_pulse), 32'h0);
    check("idle_frame_count", 32'(frame_count), 32'h1);

    // Trigger frame, CRC 0x9E
    send_frame(8'h00, 8'h10, 8'h00, 32'h0, 8'h9E, 1'b0);
    check("trig_pulse", 32'(trigger_pulse), 32'h1);
    check("trig_frame_ok", 32'(frame_ok), 32'h1);
    check("trig_last_addr", 32'(last_addr), 32'h1000);
    check("trig_last_data", last_data, 32'h0);
    idle_cycle();
    check("trig_pulse_width", {30'h0, trigger_pulse, frame_ok}, 32'h0);

    // Bad CRC
    send_frame(8'h00, 8'h10, 8'h00, 32'h0, 8'h9F, 1'b0);
    check("badcrc_crc_error", 32'(crc_error), 32'h1);
    check("badcrc_trigger", {30'h0, trigger_pulse, frame_ok}, 32'h0);
    check("badcrc_last_addr", 32'(last_addr), 32'h1000);
    check("badcrc_error_count", 32'(error_count), 32'h1);
    check("badcrc_link_up", 32'(link_up), 32'h0);
    check("badcrc_frame_count", 32'(frame_count), 32'h2);

    // Lock acquisition over four good frames
    for (int n = 1; n <= 4; n++) begin
      send_frame(8'h00, 8'h00, 8'h00, 32'h0, 8'h00, 1'b0);
      check($sformatf("lock_frame%0d", n), 32'(link_up), (n == 4) ? 32'h1 : 32'h0);
    end
    check("lock_frame_count", 32'(frame_count), 32'h6);

    // K-char 0x1C at byte 4
    send_byte(8'h3C, 1'b1); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h1C, 1'b1);
    check("kchar_frame_error", 32'(frame_error), 32'h1);
    check("kchar_link_up", 32'(link_up), 32'h0);
    check("kchar_error_count", 32'(error_count), 32'h2);
    // Remaining bytes must be ignored while hunting
    for (int i = 0; i < 4; i++) send_byte(8'h00, 1'b0);
    send_byte(8'hBC, 1'b1);
    check("kchar_hunt_quiet", {28'h0, trigger_pulse, frame_ok, crc_error, frame_error}, 32'h0);
    check("kchar_hunt_fcount", 32'(frame_count), 32'h6);

    // SOP injected at byte 5, then a full trigger frame
    send_byte(8'h3C, 1'b1); send_byte(8'h00, 1'b0); send_byte(8'h10, 1'b0);
    send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h3C, 1'b1);
    check("sop_inject_ferr", 32'(frame_error), 32'h1);
    send_byte(8'h00, 1'b0); send_byte(8'h10, 1'b0);
    for (int i = 0; i < 5; i++) send_byte(8'h00, 1'b0);
    send_byte(8'h9E, 1'b0);
    send_byte(8'hBC, 1'b1);
    check("sop_inject_trigger", 32'(trigger_pulse), 32'h1);
    check("sop_inject_ferr_end", 32'(frame_error), 32'h0);
    check("sop_inject_ecount", 32'(error_count), 32'h3);
    check("sop_inject_fcount", 32'(frame_count), 32'h7);

    // Trigger frame with alternating stalls
    send_frame(8'h00, 8'h10, 8'h00, 32'h0, 8'h9E, 1'b1);
    check("stall_trigger", 32'(trigger_pulse), 32'h1);
    check("stall_frame_ok", 32'(frame_ok), 32'h1);
    check("stall_last_addr", 32'(last_addr), 32'h1000);
    check("stall_fcount", 32'(frame_count), 32'h8);
    stall();
    check("stall_pulse_width", {30'h0, trigger_pulse, frame_ok}, 32'h0);

    // Code violation mid-frame
    send_byte(8'h3C, 1'b1); send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0, 1'b1);
    check("code_err_ferr", 32'(frame_error), 32'h1);
    check("code_err_ecount", 32'(error_count), 32'h4);

    // Reset asserted at byte 6 of a trigger frame
    send_byte(8'h3C, 1'b1); send_byte(8'h00, 1'b0); send_byte(8'h10, 1'b0);
    send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("midrst_pulses", {28'h0, trigger_pulse, frame_ok, crc_error, frame_error}, 32'h0);
    check("midrst_counts", {frame_count, error_count}, 32'h0);
    check("midrst_last_addr", 32'(last_addr), 32'h0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h9E, 1'b0); send_byte(8'hBC, 1'b1);
    check("postrst_quiet", {28'h0, trigger_pulse, frame_ok, crc_error, frame_error}, 32'h0);
    send_frame(8'h00, 8'h10, 8'h00, 32'h0, 8'h9E, 1'b0);
    check("postrst_trigger", 32'(trigger_pulse), 32'h1);
    check("postrst_fcount", 32'(frame_count), 32'h1);
    check("postrst_link_up", 32'(link_up), 32'h0);

    // Non-trivial fields: byte ordering of last_* and non-trigger control
    pay = '{8'hA5, 8'h01, 8'h42, 8'h12, 8'h34, 8'h56, 8'h78};
    crc_x = ref_crc(pay);
    send_frame(8'hA5, 8'h01, 8'h42, 32'h12345678, crc_x, 1'b0);
    check("fields_frame_ok", 32'(frame_ok), 32'h1);
    check("fields_trigger", 32'(trigger_pulse), 32'h0);
    check("fields_status", 32'(last_status), 32'hA5);
    check("fields_addr", 32'(last_addr), 32'h0142);
    check("fields_data", last_data, 32'h12345678);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
